// File: rtl/pipe_stage_reg_pkg.sv
// Shared definitions for the inter-stage pipeline register: ExcCodes, control
// bundle layout and the all-zero bubble.
package pipe_stage_reg_pkg;

    localparam int TNEW_W_DEF = 2;
    localparam int EXC_W      = 5;
    localparam int REG_W      = 5;

    typedef enum logic [EXC_W-1:0] {
        EXC_INT  = 5'd0,
        EXC_ADEL = 5'd4,
        EXC_ADES = 5'd5,
        EXC_RI   = 5'd10,
        EXC_OV   = 5'd12
    } exc_code_e;

    typedef struct packed {
        logic             valid;
        logic             regwrite;
        logic             memwrite;
        logic [REG_W-1:0] waddr;
        logic             bd;
        logic             exc_valid;
        logic [EXC_W-1:0] exc_code;
    } ctrl_t;

    localparam ctrl_t BUBBLE = '0;

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Instruction bundle entering and leaving one pipeline boundary; the stage
// logic drives the in_/loc_ side, the register drives the out_ side.
interface pipe_stage_reg_if
    import pipe_stage_reg_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int NUM_LANES = 2,
    parameter int TNEW_W    = TNEW_W_DEF
);
    logic                        in_valid;
    logic                        in_regwrite;
    logic                        in_memwrite;
    logic [REG_W-1:0]            in_waddr;
    logic [TNEW_W-1:0]           in_tnew;
    logic [31:0]                 in_pc;
    logic                        in_bd;
    logic [NUM_LANES*DATA_W-1:0] in_data;
    logic                        in_exc_valid;
    logic [EXC_W-1:0]            in_exc_code;
    logic                        loc_exc_valid;
    logic [EXC_W-1:0]            loc_exc_code;

    logic                        out_valid;
    logic                        out_regwrite;
    logic                        out_memwrite;
    logic [REG_W-1:0]            out_waddr;
    logic [TNEW_W-1:0]           out_tnew;
    logic [31:0]                 out_pc;
    logic                        out_bd;
    logic [NUM_LANES*DATA_W-1:0] out_data;
    logic                        out_exc_valid;
    logic [EXC_W-1:0]            out_exc_code;

    modport master (
        output in_valid, in_regwrite, in_memwrite, in_waddr, in_tnew, in_pc,
               in_bd, in_data, in_exc_valid, in_exc_code, loc_exc_valid, loc_exc_code,
        input  out_valid, out_regwrite, out_memwrite, out_waddr, out_tnew, out_pc,
               out_bd, out_data, out_exc_valid, out_exc_code
    );

    modport slave (
        input  in_valid, in_regwrite, in_memwrite, in_waddr, in_tnew, in_pc,
               in_bd, in_data, in_exc_valid, in_exc_code, loc_exc_valid, loc_exc_code,
        output out_valid, out_regwrite, out_memwrite, out_waddr, out_tnew, out_pc,
               out_bd, out_data, out_exc_valid, out_exc_code
    );

endinterface

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
module pipe_stage_reg_sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc_i,
    input  logic         clr_i,
    output logic [W-1:0] cnt_o
);
    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (inc_i && (cnt_q != '1))
            cnt_d = cnt_q + W'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic MIPS inter-stage register: hold, flush-to-bubble, Tnew countdown,
// in-stage exception merge with write suppression and a stall counter.
module pipe_stage_reg
    import pipe_stage_reg_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int NUM_LANES = 2,
    parameter int TNEW_W    = TNEW_W_DEF,
    parameter int TNEW_DEC  = 1,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             flush,
    input  logic             cnt_clr,
    pipe_stage_reg_if.slave  bus,
    output logic [CNT_W-1:0] stall_cnt
);
    localparam int PAY_W = NUM_LANES * DATA_W;

    ctrl_t             ctrl_q, ctrl_d, load_ctrl;
    logic [TNEW_W-1:0] tnew_q, tnew_d;
    logic [31:0]       pc_q, pc_d;
    logic [PAY_W-1:0]  data_q, data_d;
    logic              exc_any;

    function automatic logic [TNEW_W-1:0] tnew_next(input logic [TNEW_W-1:0] t);
        if (TNEW_DEC == 0)
            return t;
        else if (t == '0)
            return '0;
        else
            return t - TNEW_W'(1);
    endfunction

    // Upstream exception is older than the local one, so its code wins.
    always_comb begin
        load_ctrl = BUBBLE;
        exc_any   = bus.in_valid & (bus.in_exc_valid | bus.loc_exc_valid);

        load_ctrl.valid     = bus.in_valid;
        load_ctrl.waddr     = bus.in_waddr;
        load_ctrl.bd        = bus.in_bd;
        load_ctrl.regwrite  = bus.in_valid & bus.in_regwrite & ~exc_any;
        load_ctrl.memwrite  = bus.in_valid & bus.in_memwrite & ~exc_any;
        load_ctrl.exc_valid = exc_any;
        load_ctrl.exc_code  = EXC_INT;
        if (bus.in_valid) begin
            if (bus.in_exc_valid)
                load_ctrl.exc_code = bus.in_exc_code;
            else if (bus.loc_exc_valid)
                load_ctrl.exc_code = bus.loc_exc_code;
        end
    end

    // Flush keeps the incoming PC so the squashed slot still has a traceable EPC.
    always_comb begin
        ctrl_d = ctrl_q;
        tnew_d = tnew_q;
        pc_d   = pc_q;
        data_d = data_q;
        if (flush) begin
            ctrl_d = BUBBLE;
            tnew_d = '0;
            pc_d   = bus.in_pc;
            data_d = '0;
        end else if (en) begin
            ctrl_d = load_ctrl;
            tnew_d = tnew_next(bus.in_tnew);
            pc_d   = bus.in_pc;
            data_d = bus.in_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctrl_q <= BUBBLE;
            tnew_q <= '0;
            pc_q   <= '0;
            data_q <= '0;
        end else begin
            ctrl_q <= ctrl_d;
            tnew_q <= tnew_d;
            pc_q   <= pc_d;
            data_q <= data_d;
        end
    end

    assign bus.out_valid     = ctrl_q.valid;
    assign bus.out_regwrite  = ctrl_q.regwrite;
    assign bus.out_memwrite  = ctrl_q.memwrite;
    assign bus.out_waddr     = ctrl_q.waddr;
    assign bus.out_bd        = ctrl_q.bd;
    assign bus.out_exc_valid = ctrl_q.exc_valid;
    assign bus.out_exc_code  = ctrl_q.exc_code;
    assign bus.out_tnew      = tnew_q;
    assign bus.out_pc        = pc_q;
    assign bus.out_data      = data_q;

    pipe_stage_reg_sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc_i (~en & ~flush & ctrl_q.valid),
        .clr_i (cnt_clr),
        .cnt_o (stall_cnt)
    );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: a decrementing 16-bit-counter instance and a
// pass-through 4-bit-counter instance driven in lockstep, checked via a queue.
module tb_pipe_stage_reg;
    import pipe_stage_reg_pkg::*;

    typedef struct packed {
        logic        valid;
        logic        regwrite;
        logic        memwrite;
        logic [4:0]  waddr;
        logic [1:0]  tnew;
        logic [1:0]  tnew_b;
        logic [31:0] pc;
        logic        bd;
        logic [63:0] data;
        logic        exc_valid;
        logic [4:0]  exc_code;
        logic [15:0] cnt;
        logic [3:0]  cnt_b;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        en = 1'b0;
    logic        flush = 1'b0;
    logic        cnt_clr = 1'b0;
    logic [15:0] stall_a;
    logic [3:0]  stall_b;

    int   errors = 0;
    int   checks = 0;
    exp_t exp_q[$];
    exp_t e;

    pipe_stage_reg_if #(.DATA_W(32), .NUM_LANES(2), .TNEW_W(2)) ifa ();
    pipe_stage_reg_if #(.DATA_W(32), .NUM_LANES(2), .TNEW_W(2)) ifb ();

    pipe_stage_reg #(.DATA_W(32), .NUM_LANES(2), .TNEW_W(2), .TNEW_DEC(1), .CNT_W(16)) dut_a (
        .clk(clk), .reset(reset), .en(en), .flush(flush), .cnt_clr(cnt_clr),
        .bus(ifa), .stall_cnt(stall_a)
    );

    pipe_stage_reg #(.DATA_W(32), .NUM_LANES(2), .TNEW_W(2), .TNEW_DEC(0), .CNT_W(4)) dut_b (
        .clk(clk), .reset(reset), .en(en), .flush(flush), .cnt_clr(cnt_clr),
        .bus(ifb), .stall_cnt(stall_b)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic check_all(input exp_t x);
        chk("out_valid",     64'(ifa.out_valid),     64'(x.valid));
        chk("out_regwrite",  64'(ifa.out_regwrite),  64'(x.regwrite));
        chk("out_memwrite",  64'(ifa.out_memwrite),  64'(x.memwrite));
        chk("out_waddr",     64'(ifa.out_waddr),     64'(x.waddr));
        chk("out_tnew",      64'(ifa.out_tnew),      64'(x.tnew));
        chk("out_pc",        64'(ifa.out_pc),        64'(x.pc));
        chk("out_bd",        64'(ifa.out_bd),        64'(x.bd));
        chk("out_data",      ifa.out_data,           x.data);
        chk("out_exc_valid", 64'(ifa.out_exc_valid), 64'(x.exc_valid));
        chk("out_exc_code",  64'(ifa.out_exc_code),  64'(x.exc_code));
        chk("stall_cnt",     64'(stall_a),           64'(x.cnt));
        chk("b_out_tnew",    64'(ifb.out_tnew),      64'(x.tnew_b));
        chk("b_stall_cnt",   64'(stall_b),           64'(x.cnt_b));
    endtask

    task automatic step(input exp_t x);
        exp_t got;
        exp_q.push_back(x);
        @(posedge clk);
        #1;
        got = exp_q.pop_front();
        check_all(got);
    endtask

    task automatic check_now(input exp_t x);
        exp_t got;
        exp_q.push_back(x);
        got = exp_q.pop_front();
        check_all(got);
    endtask

    task automatic drive(input logic v, input logic rw, input logic mw, input logic [4:0] wa,
                         input logic [1:0] tn, input logic [31:0] pc, input logic bd,
                         input logic [63:0] d, input logic iev, input logic [4:0] iec,
                         input logic lev, input logic [4:0] lec);
        ifa.in_valid = v;      ifb.in_valid = v;
        ifa.in_regwrite = rw;  ifb.in_regwrite = rw;
        ifa.in_memwrite = mw;  ifb.in_memwrite = mw;
        ifa.in_waddr = wa;     ifb.in_waddr = wa;
        ifa.in_tnew = tn;      ifb.in_tnew = tn;
        ifa.in_pc = pc;        ifb.in_pc = pc;
        ifa.in_bd = bd;        ifb.in_bd = bd;
        ifa.in_data = d;       ifb.in_data = d;
        ifa.in_exc_valid = iev;  ifb.in_exc_valid = iev;
        ifa.in_exc_code = iec;   ifb.in_exc_code = iec;
        ifa.loc_exc_valid = lev; ifb.loc_exc_valid = lev;
        ifa.loc_exc_code = lec;  ifb.loc_exc_code = lec;
    endtask

    initial begin
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        e = '0;
        check_now(e);
        reset = 1'b1;

        // Normal load, lane 0 in the LSBs
        en = 1'b1;
        drive(1, 1, 0, 5'd8, 2'd2, 32'h3000, 0, 64'h0000_1234_0000_ABCD, 0, 0, 0, 0);
        e = '0;
        e.valid = 1; e.regwrite = 1; e.waddr = 5'd8; e.tnew = 2'd1; e.tnew_b = 2'd2;
        e.pc = 32'h3000; e.data = 64'h0000_1234_0000_ABCD;
        step(e);

        // Tnew already zero stays zero
        drive(1, 0, 1, 5'd9, 2'd0, 32'h3004, 1, 64'h5555_0000_0000_AAAA, 0, 0, 0, 0);
        e.regwrite = 0; e.memwrite = 1; e.waddr = 5'd9; e.tnew = 2'd0; e.tnew_b = 2'd0;
        e.pc = 32'h3004; e.bd = 1; e.data = 64'h5555_0000_0000_AAAA;
        step(e);

        drive(1, 1, 0, 5'd10, 2'd3, 32'h3008, 0, 64'hDEAD_BEEF_0123_4567, 0, 0, 0, 0);
        e.regwrite = 1; e.memwrite = 0; e.waddr = 5'd10; e.tnew = 2'd2; e.tnew_b = 2'd3;
        e.pc = 32'h3008; e.bd = 0; e.data = 64'hDEAD_BEEF_0123_4567;
        step(e);

        // Hold three cycles with changing inputs
        en = 1'b0;
        drive(1, 0, 1, 5'd31, 2'd1, 32'hFFFF_FFF0, 1, '1, 1, 5'd10, 1, 5'd12);
        for (int i = 1; i <= 3; i++) begin
            e.cnt = 16'(i); e.cnt_b = 4'(i);
            step(e);
        end

        // Flush while stalled: bubble, PC tracks input, counter frozen
        flush = 1'b1;
        e.valid = 0; e.regwrite = 0; e.memwrite = 0; e.waddr = 0; e.tnew = 0; e.tnew_b = 0;
        e.pc = 32'hFFFF_FFF0; e.bd = 0; e.data = 0; e.exc_valid = 0; e.exc_code = 0;
        step(e);

        // Stalled bubble does not count
        flush = 1'b0;
        step(e);

        // Local overflow suppresses both writes
        en = 1'b1;
        drive(1, 1, 1, 5'd11, 2'd1, 32'h3010, 0, 64'h1111_2222_3333_4444, 0, 0, 1, EXC_OV);
        e.valid = 1; e.regwrite = 0; e.memwrite = 0; e.waddr = 5'd11; e.tnew = 2'd0; e.tnew_b = 2'd1;
        e.pc = 32'h3010; e.bd = 0; e.data = 64'h1111_2222_3333_4444; e.exc_valid = 1; e.exc_code = 5'd12;
        step(e);

        // Upstream exception wins over local
        drive(1, 1, 0, 5'd12, 2'd2, 32'h3014, 1, 64'h2, 1, EXC_ADEL, 1, EXC_OV);
        e.waddr = 5'd12; e.tnew = 2'd1; e.tnew_b = 2'd2; e.pc = 32'h3014; e.bd = 1;
        e.data = 64'h2; e.exc_code = 5'd4;
        step(e);

        // Bubble input masks writes and exceptions
        drive(0, 1, 1, 5'd13, 2'd2, 32'h3018, 0, 64'h3, 1, EXC_ADES, 1, EXC_OV);
        e.valid = 0; e.waddr = 5'd13; e.pc = 32'h3018; e.bd = 0; e.data = 64'h3;
        e.exc_valid = 0; e.exc_code = 0;
        step(e);

        drive(1, 1, 0, 5'd14, 2'd0, 32'h301C, 0, 64'h4, 0, 0, 0, 0);
        e.valid = 1; e.regwrite = 1; e.waddr = 5'd14; e.tnew = 0; e.tnew_b = 0;
        e.pc = 32'h301C; e.data = 64'h4;
        step(e);

        // Long stall: 4-bit counter saturates at 15
        en = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            e.cnt = 16'(3 + i);
            e.cnt_b = (3 + i > 15) ? 4'd15 : 4'(3 + i);
            step(e);
        end

        cnt_clr = 1'b1;
        e.cnt = 0; e.cnt_b = 0;
        step(e);

        cnt_clr = 1'b0;
        e.cnt = 1; e.cnt_b = 1;
        step(e);

        // Asynchronous reset mid-cycle while loaded
        #3;
        reset = 1'b0;
        #1;
        e = '0;
        check_now(e);

        en = 1'b1;
        drive(1, 1, 1, 5'd5, 2'd2, 32'h3020, 0, 64'h77, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        check_now(e);

        reset = 1'b1;
        e.valid = 1; e.regwrite = 1; e.memwrite = 1; e.waddr = 5'd5; e.tnew = 2'd1; e.tnew_b = 2'd2;
        e.pc = 32'h3020; e.data = 64'h77;
        step(e);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised inter-stage pipeline register for the 5-stage MIPS core with precise exceptions; one instance per boundary (D/E, E/M, M/W).
- Adds hold (stall), flush-to-bubble, a valid bit, saturating Tnew countdown and in-stage exception merge with write suppression.
- Adds a saturating stall-cycle counter for debug.
- Payload lanes are generic, so one module replaces the per-boundary hand-written registers.

Parameters:
- DATA_W, 32, width of each payload lane (ALU result, store data, etc.)
- NUM_LANES, 2, number of payload lanes carried
- TNEW_W, 2, width of Tnew field
- TNEW_DEC, 1, 1 = decrement Tnew on advance (saturating at 0), 0 = pass through unchanged
- CNT_W, 16, stall counter width

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous active-low reset
- en  in  1  advance enable; 0 = hold current contents
- flush  in  1  replace contents with bubble on next edge (CLR)
- cnt_clr  in  1  synchronous clear of stall counter
- in_valid  in  1  upstream holds a real instruction
- in_regwrite  in  1  GPR write enable
- in_memwrite  in  1  data memory write enable
- in_waddr  in  5  GPR destination
- in_tnew  in  TNEW_W  cycles until result ready
- in_pc  in  32  instruction PC
- in_bd  in  1  instruction sits in a branch delay slot
- in_data  in  NUM_LANES*DATA_W  payload, lane 0 in LSBs
- in_exc_valid  in  1  exception raised upstream
- in_exc_code  in  5  upstream ExcCode
- loc_exc_valid  in  1  exception raised by the current stage (e.g. overflow)
- loc_exc_code  in  5  current-stage ExcCode
- out_valid, out_regwrite, out_memwrite  out  1 each  registered fields
- out_waddr  out  5  registered field
- out_tnew  out  TNEW_W  registered field
- out_pc  out  32  registered field
- out_bd  out  1  registered field
- out_data  out  NUM_LANES*DATA_W  registered field
- out_exc_valid  out  1  merged exception flag
- out_exc_code  out  5  merged ExcCode
- stall_cnt  out  CNT_W  cycles with en=0 and out_valid=1

Behaviour:
- Reset is asynchronous and active-low. While reset=0, every output is 0, including stall_cnt.
- Priority per rising edge: flush > hold (en=0) > load (en=1).
- Flush:
  - All fields go to 0 (bubble); out_pc keeps in_pc so EPC of the flushed slot stays traceable.
  - flush with en=0 still flushes.
- Hold: all outputs keep their value, Tnew included (no decrement while stalled).
- Load:
  - out_valid takes in_valid; pc, bd, data and waddr copy from the inputs.
  - If TNEW_DEC=1: out_tnew = (in_tnew==0) ? 0 : in_tnew-1. If TNEW_DEC=0: out_tnew = in_tnew.
- Exception merge on load (upstream exception is older, so it wins):
  - in_exc_valid=1: out_exc_code = in_exc_code.
  - Else loc_exc_valid=1: out_exc_code = loc_exc_code.
  - Else: out_exc_code = 0.
  - out_exc_valid = in_exc_valid | loc_exc_valid.
- Write suppression: when the merged exception is set, out_regwrite=0 and out_memwrite=0 regardless of the inputs, so no architectural side effect occurs.
- Bubble rule: in_valid=0 forces out_regwrite, out_memwrite, out_exc_valid and out_exc_code to 0.
- Latency: one cycle from inputs to outputs when en=1; no combinational path from input to output.
- Stall counter:
  - Increments by 1 on each edge with en=0, flush=0 and out_valid=1.
  - Saturates at all-ones.
  - cnt_clr clears it to 0 and has priority over the increment.
- Reset mid-stall: all state is discarded; the first edge after release behaves as a normal load.

Decomposition:
- Shared package: ExcCode constants (EXC_INT=0, EXC_ADEL=4, EXC_ADES=5, EXC_RI=10, EXC_OV=12), the BUBBLE zero constant, and the TNEW_W default.
- One natural sub-module, sat_counter (width CNT_W, inc, clr), used for stall_cnt.
- The exception merge stays inline.

Test Plan:
1. Reset: pulse reset=0 mid-cycle with the register loaded -> all outputs 0 immediately, without waiting for a clock edge.
2. Normal load:
   - Stimulus: en=1, in_valid=1, in_tnew=2, in_waddr=8, in_data={32'h1234, 32'hABCD}, in_pc=32'h3000.
   - Required next cycle: out_tnew=1, out_waddr=8, out_data identical, out_pc=32'h3000.
3. Tnew saturation: in_tnew=0 -> out_tnew=0; with TNEW_DEC=0, in_tnew=2 -> out_tnew=2.
4. Hold then flush:
   - Load, then en=0 for 3 cycles -> outputs frozen and stall_cnt=3.
   - Then flush=1 with en=0 -> out_valid=0, out_regwrite=0, stall_cnt stays 3.
5. Exception merge:
   - loc_exc_valid=1, code 12, in_regwrite=1 -> out_exc_code=12, out_regwrite=0.
   - in_exc_valid=1 (code 4) together with loc code 12 -> out_exc_code=4.
6. Counter saturation and clear:
   - CNT_W=4, hold 20 cycles -> stall_cnt=15.
   - cnt_clr=1 on the same edge as a hold cycle -> stall_cnt=0.
